// File: rtl/frame_minmax.sv
// Per-frame min/max/count reducer: accumulates samples until in_last, then holds the result until the consumer takes it.
// Optional FRAME_MINMAX_INDEX_EN adds the zero-based positions of the retained max/min samples.
module frame_minmax #(
  parameter int unsigned word  = 16,
  parameter int unsigned cnt_w = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [word-1:0]  in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [word-1:0]  out_max,
  output logic [word-1:0]  out_min,
  output logic [cnt_w-1:0] out_count,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FRAME_MINMAX_INDEX_EN
  ,
  output logic [cnt_w-1:0] out_max_idx,
  output logic [cnt_w-1:0] out_min_idx
`endif
);

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [cnt_w-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             have_q, have_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [word-1:0]  run_max_q, run_max_d, run_min_q, run_min_d;
  logic [cnt_w-1:0] run_cnt_q, run_cnt_d;
  logic [word-1:0]  out_max_q, out_max_d, out_min_q, out_min_d;
  logic [cnt_w-1:0] out_count_q, out_count_d;

  logic             accept;
  logic             take_max, take_min;
  logic [word-1:0]  nxt_max, nxt_min;
  logic [cnt_w-1:0] nxt_cnt;

`ifdef FRAME_MINMAX_INDEX_EN
  logic [cnt_w-1:0] run_max_idx_q, run_max_idx_d, run_min_idx_q, run_min_idx_d;
  logic [cnt_w-1:0] out_max_idx_q, out_max_idx_d, out_min_idx_q, out_min_idx_d;
  logic [cnt_w-1:0] pos, nxt_max_idx, nxt_min_idx;
`endif

  // Frame datapath and handshake control
  always_comb begin
    accept   = in_valid && in_ready_q;
    take_max = !have_q || (in_data > run_max_q);
    take_min = !have_q || (in_data < run_min_q);
    nxt_max  = take_max ? in_data : run_max_q;
    nxt_min  = take_min ? in_data : run_min_q;
    if (!have_q)                    nxt_cnt = cnt_w'(1);
    else if (run_cnt_q == CNT_MAX)  nxt_cnt = run_cnt_q;
    else                            nxt_cnt = run_cnt_q + cnt_w'(1);

    state_d     = state_q;
    have_d      = have_q;
    out_valid_d = out_valid_q;
    run_max_d   = run_max_q;
    run_min_d   = run_min_q;
    run_cnt_d   = run_cnt_q;
    out_max_d   = out_max_q;
    out_min_d   = out_min_q;
    out_count_d = out_count_q;
`ifdef FRAME_MINMAX_INDEX_EN
    // Running count equals the saturated position of the incoming sample
    pos           = have_q ? run_cnt_q : '0;
    nxt_max_idx   = take_max ? pos : run_max_idx_q;
    nxt_min_idx   = take_min ? pos : run_min_idx_q;
    run_max_idx_d = run_max_idx_q;
    run_min_idx_d = run_min_idx_q;
    out_max_idx_d = out_max_idx_q;
    out_min_idx_d = out_min_idx_q;
`endif

    case (state_q)
      ACC: begin
        if (accept) begin
          if (in_last) begin
            out_max_d   = nxt_max;
            out_min_d   = nxt_min;
            out_count_d = nxt_cnt;
            out_valid_d = 1'b1;
            state_d     = HOLD;
            have_d      = 1'b0;
            run_max_d   = '0;
            run_min_d   = '0;
            run_cnt_d   = '0;
`ifdef FRAME_MINMAX_INDEX_EN
            out_max_idx_d = nxt_max_idx;
            out_min_idx_d = nxt_min_idx;
            run_max_idx_d = '0;
            run_min_idx_d = '0;
`endif
          end else begin
            have_d    = 1'b1;
            run_max_d = nxt_max;
            run_min_d = nxt_min;
            run_cnt_d = nxt_cnt;
`ifdef FRAME_MINMAX_INDEX_EN
            run_max_idx_d = nxt_max_idx;
            run_min_idx_d = nxt_min_idx;
`endif
          end
        end
      end
      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase

    in_ready_d = (state_d == ACC);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      have_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      run_max_q   <= '0;
      run_min_q   <= '0;
      run_cnt_q   <= '0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      out_count_q <= '0;
`ifdef FRAME_MINMAX_INDEX_EN
      run_max_idx_q <= '0;
      run_min_idx_q <= '0;
      out_max_idx_q <= '0;
      out_min_idx_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      have_q      <= have_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      run_max_q   <= run_max_d;
      run_min_q   <= run_min_d;
      run_cnt_q   <= run_cnt_d;
      out_max_q   <= out_max_d;
      out_min_q   <= out_min_d;
      out_count_q <= out_count_d;
`ifdef FRAME_MINMAX_INDEX_EN
      run_max_idx_q <= run_max_idx_d;
      run_min_idx_q <= run_min_idx_d;
      out_max_idx_q <= out_max_idx_d;
      out_min_idx_q <= out_min_idx_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_min   = out_min_q;
  assign out_count = out_count_q;
`ifdef FRAME_MINMAX_INDEX_EN
  assign out_max_idx = out_max_idx_q;
  assign out_min_idx = out_min_idx_q;
`endif

endmodule

// File: doc/frame_minmax.md
FRAME_MINMAX -- requirements
Module: frame_minmax

Interface
REQ-001 SHALL have parameter: word, 16, sample width in bits (unsigned).
REQ-002 SHALL have parameter: cnt_w, 8, width of sample count/index fields.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: in_data  input  word  sample value.
REQ-006 SHALL have port: in_valid  input  1  sample present.
REQ-007 SHALL have port: in_last  input  1  sample is last of frame; qualified by in_valid.
REQ-008 SHALL have port: in_ready  output  1  block accepts sample this cycle.
REQ-009 SHALL have port: out_max  output  word  largest sample of completed frame.
REQ-010 SHALL have port: out_min  output  word  smallest sample of completed frame.
REQ-011 SHALL have port: out_count  output  cnt_w  samples in completed frame (saturating).
REQ-012 SHALL have port: out_valid  output  1  result available.
REQ-013 SHALL have port: out_ready  input  1  consumer takes result.

Function
REQ-014 SHALL implement two-state FSM: ACC (accumulating) and HOLD (result pending).
REQ-015 SHALL drive in_ready=1 in ACC, 0 in HOLD; accept = in_valid && in_ready.
REQ-016 SHALL, on first accept of a frame, load running max and min both with in_data and running count with 1.
REQ-017 SHALL, on later accepts, replace running max only if in_data > max and running min only if in_data < min (unsigned, strict; ties keep earlier value).
REQ-018 SHALL increment running count per accept, saturating at 2^cnt_w-1.
REQ-019 SHALL, on accept with in_last=1, include that sample, copy final max/min/count to out_* and assert out_valid on the next cycle (latency 1), and enter HOLD.
REQ-020 SHALL treat an accepted sample with in_last=1 as first-and-last of a one-sample frame when no prior sample: out_max=out_min=in_data, out_count=1.
REQ-021 SHALL hold out_* and out_valid stable in HOLD until out_valid && out_ready, then deassert out_valid next cycle, clear frame state, return to ACC.
REQ-022 SHALL hold out_max/out_min/out_count at last delivered values while in ACC; out_valid=0 in ACC.
REQ-023 SHALL ignore in_data/in_last when in_valid=0 or in_ready=0.
REQ-024 SHALL not accept a new sample in the cycle the result handshake completes (in_ready rises the following cycle).

Reset
REQ-025 SHALL, while rst_n=0, force state=ACC, out_valid=0, out_max=0, out_min=0, out_count=0, running frame state cleared, independent of clk.
REQ-026 SHALL discard any partial frame or pending result when reset asserts mid-operation; first accept after release starts a new frame.

Configuration
REQ-027 SHALL, when macro FRAME_MINMAX_INDEX_EN is defined, add outputs out_max_idx and out_min_idx (cnt_w each): zero-based position within frame of the retained max/min sample (first occurrence on ties), positions saturating at 2^cnt_w-1, reset 0, updated and held as out_max.
REQ-028 SHALL, when FRAME_MINMAX_INDEX_EN is undefined, omit those ports and their logic; all other behaviour identical.

Verification
REQ-029 SHALL test frame 5,9,2,9(last) with out_ready=1 -> out_max=9, out_min=2, out_count=4, out_valid one cycle after last; with macro max_idx=1, min_idx=2.
REQ-030 SHALL test single sample 0xFFFF with in_last=1 -> out_max=out_min=0xFFFF, out_count=1.
REQ-031 SHALL test out_ready=0 for 10 cycles after result -> in_ready=0, outputs stable, in_valid pulses ignored; out_ready=1 -> out_valid falls next cycle, in_ready=1 the cycle after handshake.
REQ-032 SHALL test cnt_w=8, 300-sample frame -> out_count=255.
REQ-033 SHALL test rst_n low after 3 samples of a frame -> outputs 0 immediately; new frame 7,3(last) -> max=7, min=3, count=2.
